main_memory: RTL and testbench

//  Backing main memory for the basic processor: array of DEPTH lines, each DATA_WIDTH bits.

---
 rtl/main_memory_pkg.sv | 16 +
 rtl/main_memory_bank.sv | 29 ++
 rtl/main_memory.sv | 79 +++++++
 tb/tb_main_memory.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/main_memory_pkg.sv
// Shared constants for the main memory: line width, depth and the address split.
// Line width comes from `MEM_DATA_WIDTH (default 128); `MEM_DATA_SIZE aliases it.
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 128
`endif
`ifndef MEM_DATA_SIZE
`define MEM_DATA_SIZE `MEM_DATA_WIDTH
`endif

package main_memory_pkg;
   localparam int MEM_DATA_WIDTH = `MEM_DATA_WIDTH;
   localparam int MEM_DEPTH      = 128;
   localparam int MEM_ADDR_WIDTH = 32;
   localparam int MEM_OFS_BITS   = $clog2(MEM_DATA_WIDTH / 8);
   localparam int MEM_IDX_BITS   = $clog2(MEM_DEPTH);
endpackage

// File: rtl/main_memory_bank.sv
// DEPTH x DW register array: synchronous clear of every line, one write port,
// one asynchronous read port (the caller registers the read data).
module main_memory_bank #(
   parameter int DW    = 128,
   parameter int DEPTH = 128,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_clr,
   input  logic          i_we,
   input  logic [IW-1:0] i_widx,
   input  logic [DW-1:0] i_wdata,
   input  logic [IW-1:0] i_ridx,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[i_widx] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/main_memory.sv
// Single-port line memory with registered, write-first read data.
// Define MAIN_MEMORY_ADDR_CHECK_EN to add addr_err and reject out-of-range addresses.
module main_memory
   import main_memory_pkg::*;
#(
   parameter int DATA_WIDTH = MEM_DATA_WIDTH,
   parameter int DEPTH      = MEM_DEPTH,
   parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data_to_write,
   input  logic                  wrt_en,
   output logic [DATA_WIDTH-1:0] data_to_read
`ifdef MAIN_MEMORY_ADDR_CHECK_EN
   ,
   output logic                  addr_err
`endif
);

   localparam int OFS = $clog2(DATA_WIDTH / 8);
   localparam int IDX = $clog2(DEPTH);

   logic [IDX-1:0]        w_idx;
   logic                  w_addr_bad;
   logic                  w_we;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic [DATA_WIDTH-1:0] r_rd_data;

   assign w_idx = addr[OFS +: IDX];

`ifdef MAIN_MEMORY_ADDR_CHECK_EN
   logic r_addr_err;
   logic w_unused_ofs;

   assign w_addr_bad   = |addr[ADDR_WIDTH-1:OFS+IDX];
   assign w_unused_ofs = ^addr[OFS-1:0];
   assign addr_err     = r_addr_err;

   always_ff @(posedge clk) begin
      if (reset) r_addr_err <= 1'b0;
      else       r_addr_err <= w_addr_bad;
   end
`else
   // Upper bits and byte offset do not take part in decode: addresses wrap.
   logic w_unused_addr;

   assign w_addr_bad    = 1'b0;
   assign w_unused_addr = ^{addr[ADDR_WIDTH-1:OFS+IDX], addr[OFS-1:0]};
`endif

   assign w_we = wrt_en & ~w_addr_bad;

   main_memory_bank #(
      .DW    (DATA_WIDTH),
      .DEPTH (DEPTH),
      .IW    (IDX)
   ) u_bank (
      .i_clk   (clk),
      .i_clr   (reset),
      .i_we    (w_we),
      .i_widx  (w_idx),
      .i_wdata (data_to_write),
      .i_ridx  (w_idx),
      .o_rdata (w_rdata)
   );

   // Read and write share one index, so a write always forwards its own data.
   always_ff @(posedge clk) begin
      if (reset)           r_rd_data <= '0;
      else if (w_addr_bad) r_rd_data <= '0;
      else if (wrt_en)     r_rd_data <= data_to_write;
      else                 r_rd_data <= w_rdata;
   end

   assign data_to_read = r_rd_data;

endmodule

// File: tb/tb_main_memory.sv
// Randomized bench for main_memory against a line-array model, plus directed
// scenarios with hand-computed literal results.
module tb_main_memory;

   localparam logic [127:0] V2 = 128'h0000_0000_0000_0000_0000_FFFF_FFFF_0000;
   localparam logic [127:0] V4 = 128'hFFFF_AAAA_CCCC_EEEE_0000_FFFF_FFFF_1234;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [31:0]  addr = '0;
   logic [127:0] data_to_write = '0;
   logic         wrt_en = 1'b0;
   logic [127:0] data_to_read;
`ifdef MAIN_MEMORY_ADDR_CHECK_EN
   logic         addr_err;
`endif

   int checks = 0;
   int failures = 0;

   main_memory dut (
      .clk           (clk),
      .reset         (reset),
      .addr          (addr),
      .data_to_write (data_to_write),
      .wrt_en        (wrt_en),
      .data_to_read  (data_to_read)
`ifdef MAIN_MEMORY_ADDR_CHECK_EN
      ,
      .addr_err      (addr_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Behavioural model: 128 lines of 16 bytes, line = (addr / 16) mod 128.
   logic [127:0] m_mem [128];
   logic [127:0] m_exp = '0;
   logic         m_err = 1'b0;
   bit           m_vld = 1'b0;

   always @(posedge clk) begin
      int  line;
      bit  bad;
      line = int'((addr / 32'd16) % 32'd128);
`ifdef MAIN_MEMORY_ADDR_CHECK_EN
      bad = (addr >= 32'd2048);
`else
      bad = 1'b0;
`endif
      if (reset) begin
         for (int i = 0; i < 128; i++) m_mem[i] = '0;
         m_exp = '0;
         m_err = 1'b0;
         m_vld = 1'b1;
      end else begin
         if (wrt_en && !bad) m_mem[line] = data_to_write;
         m_exp = bad ? 128'd0 : m_mem[line];
         m_err = bad;
      end
   end

   always @(negedge clk) begin
      if (m_vld) begin
         check("model_rd", data_to_read, m_exp);
`ifdef MAIN_MEMORY_ADDR_CHECK_EN
         check("model_err", {127'd0, addr_err}, {127'd0, m_err});
`endif
      end
   end

   // Apply inputs at a falling edge, return at the falling edge after the consuming rise.
   task automatic cyc(input logic rst, input logic we, input logic [31:0] a, input logic [127:0] d);
      reset = rst;
      wrt_en = we;
      addr = a;
      data_to_write = d;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] ra;
      @(negedge clk);

      // 1: reset then reads of line 0 aliases and 0xFF5
      cyc(1, 0, 32'h0, '0);
      check("rst_out", data_to_read, 128'd0);
      cyc(0, 0, 32'h0, '0);   check("rd_0x0", data_to_read, 128'd0);
      cyc(0, 0, 32'h5, '0);   check("rd_0x5", data_to_read, 128'd0);
      cyc(0, 0, 32'h9, '0);   check("rd_0x9", data_to_read, 128'd0);
      cyc(0, 0, 32'hF, '0);   check("rd_0xF", data_to_read, 128'd0);
      cyc(0, 0, 32'hFF5, '0); check("rd_0xFF5", data_to_read, 128'd0);

      // 2: overwrite held for several cycles
      cyc(0, 1, 32'h0, '0);   check("ow_zero", data_to_read, 128'd0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 32'h0, V2); check("ow_hold", data_to_read, V2);
      end
      cyc(0, 0, 32'h0, '0);   check("ow_read", data_to_read, V2);

      // 3: flush
      cyc(1, 0, 32'h0, '0);
      cyc(0, 0, 32'h0, '0);   check("flush_0x0", data_to_read, 128'd0);
      cyc(0, 0, 32'h5, '0);   check("flush_0x5", data_to_read, 128'd0);

      // 4: write-first after flush
      cyc(0, 1, 32'h0, V4);   check("wf_same", data_to_read, V4);
      cyc(0, 0, 32'h0, '0);   check("wf_later", data_to_read, V4);
      cyc(0, 0, 32'h10, '0);  check("wf_line1", data_to_read, 128'd0);

      // 5: wrap / offset
`ifdef MAIN_MEMORY_ADDR_CHECK_EN
      cyc(0, 1, 32'h1000, 128'h1);
      check("oor_rd", data_to_read, 128'd0);
      check("oor_err", {127'd0, addr_err}, 128'd1);
      cyc(0, 0, 32'h0, '0);
      check("oor_line0", data_to_read, V4);
      check("oor_err_clr", {127'd0, addr_err}, 128'd0);
`else
      cyc(0, 1, 32'h0FF5, 128'h1);
      cyc(0, 0, 32'h7F0, '0); check("wrap_rd", data_to_read, 128'h1);
      cyc(0, 0, 32'h0, '0);   check("wrap_line0", data_to_read, V4);
`endif

      // 6: reset wins over a concurrent write
      cyc(1, 1, 32'h20, 128'hDEAD);
      cyc(0, 0, 32'h20, '0);  check("rst_wr_drop", data_to_read, 128'd0);

      // Random traffic, mostly in-range so lines get reused
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 15) == 0) ra = $urandom();
         else                            ra = $urandom_range(0, 2047);
         cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 1), ra,
             {$urandom(), $urandom(), $urandom(), $urandom()});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
